// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream input and instruction-memory write bus of the boot loader
//  rx_data/rx_valid/rx_ready : host byte stream, byte taken when rx_valid & rx_ready
//  mem_we/mem_addr/mem_wdata : one-cycle word write into insMEM
//  master = host/memory side, slave = loader side
interface imem_boot_loader_if #(parameter int ADDR_W = 8) ();
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   modport master (output rx_data, rx_valid, input rx_ready, mem_we, mem_addr, mem_wdata);
   modport slave (input rx_data, rx_valid, output rx_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length/payload/checksum byte frame into insMEM and holds the core until verified
//  clk, arst    : clock, synchronous active-high reset
//  start        : begin load (honoured in IDLE, DONE, ERROR)
//  bus          : byte stream in, instruction-memory write port out
//  core_hold    : 1 keeps the core in reset
//  done, error  : image verified / bad length or checksum
//  words_loaded : words written in the current load
module imem_boot_loader #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic                clk,
   input  logic                arst,
   input  logic                start,
   imem_boot_loader_if.slave   bus,
   output logic                core_hold,
   output logic                done,
   output logic                error,
   output logic [15:0]         words_loaded
);
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;
   state_t            state, state_n;
   logic [7:0]        len_lo, acc;
   logic [15:0]       lval;
   logic [1:0]        bcnt;
   logic [ADDR_W-1:0] widx, last;
   logic [23:0]       asm_w;
   logic              take, go;
   // rx_ready mirrors the active states, so a take can only happen in LEN_LO..CSUM
   always_comb begin
      take = bus.rx_valid & bus.rx_ready;
      go = start & (state == IDLE || state == DONE || state == ERROR);
      lval = {bus.rx_data, len_lo};
      state_n = go ? LEN_LO : !take ? state :
                state == LEN_LO ? LEN_HI :
                state == LEN_HI ? ((lval == '0 || lval > 16'(DEPTH_WORDS)) ? ERROR : DATA) :
                state == DATA ? ((bcnt == 2'd3 && widx == last) ? CSUM : DATA) :
                (bus.rx_data == acc ? DONE : ERROR);
   end
   always_ff @(posedge clk) state <= arst ? IDLE : state_n;
   // outputs are registered from the next state so they line up with the state register
   always_ff @(posedge clk) begin
      if (arst) begin
         bus.rx_ready <= 1'b0;
         bus.mem_we <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_wdata <= '0;
         core_hold <= 1'b1;
         done <= 1'b0;
         error <= 1'b0;
         words_loaded <= '0;
         len_lo <= '0;
         last <= '0;
         acc <= '0;
         bcnt <= '0;
         widx <= '0;
         asm_w <= '0;
      end else begin
         bus.rx_ready <= state_n inside {LEN_LO, LEN_HI, DATA, CSUM};
         done <= state_n == DONE;
         error <= state_n == ERROR;
         core_hold <= state_n != DONE;
         bus.mem_we <= take && state == DATA && bcnt == 2'd3;
         words_loaded <= go ? '0 : words_loaded + 16'(bus.mem_we);
         if (go) begin
            bcnt <= '0;
            widx <= '0;
            acc <= '0;
         end
         if (take && state == LEN_LO) len_lo <= bus.rx_data;
         if (take && state == LEN_HI) last <= ADDR_W'(lval - 16'd1);
         if (take && state == DATA) begin
            acc <= acc ^ bus.rx_data;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
               // completed word moves to the holding register; asm_w is free for the next word
               bus.mem_wdata <= {bus.rx_data, asm_w};
               bus.mem_addr <= widx;
               widx <= widx + ADDR_W'(1);
            end else asm_w[8*bcnt +: 8] <= bus.rx_data;
         end
      end
   end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table, hand and random frames checked against a frame-level model
module tb_imem_boot_loader;
   logic clk = 1'b0;
   logic arst, start, core_hold, done, error;
   logic [15:0] words_loaded;
   imem_boot_loader_if #(.ADDR_W(8)) bus ();
   imem_boot_loader #(.DEPTH_WORDS(256), .ADDR_W(8)) dut (
      .clk(clk), .arst(arst), .start(start), .bus(bus.slave),
      .core_hold(core_hold), .done(done), .error(error), .words_loaded(words_loaded)
   );
   always #5 clk = ~clk;
   typedef struct {int len; bit bad; bit e_done; bit e_err; int e_words;} vec_t;
   vec_t tv[7];
   int checks = 0, failures = 0, dbl = 0;
   logic prev_we = 1'b0;
   logic [39:0] wq[$], eq[$];
   logic [7:0] fr[$];
   logic [7:0] t2[11];
   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (arst) prev_we = 1'b0;
      else begin
         if (bus.mem_we) begin
            wq.push_back({bus.mem_addr, bus.mem_wdata});
            if (prev_we) dbl++;
         end
         prev_we = bus.mem_we;
      end
   end
   task automatic model(output logic e_done, output logic e_err, output int e_words, output int e_len);
      int l;
      logic [7:0] x;
      l = int'({fr[1], fr[0]});
      eq.delete();
      if (l == 0 || l > 256) begin
         e_done = 1'b0; e_err = 1'b1; e_words = 0; e_len = 2;
         return;
      end
      x = 8'h00;
      for (int i = 0; i < l; i++) begin
         eq.push_back({8'(i), fr[2+4*i+3], fr[2+4*i+2], fr[2+4*i+1], fr[2+4*i]});
         for (int j = 0; j < 4; j++) x ^= fr[2+4*i+j];
      end
      e_done = fr[2+4*l] == x;
      e_err = !e_done;
      e_words = l;
      e_len = 3 + 4*l;
   endtask
   task automatic build(input int l, input bit bad);
      logic [7:0] x, b;
      fr.delete();
      fr.push_back(l[7:0]);
      fr.push_back(l[15:8]);
      x = 8'h00;
      if (l >= 1 && l <= 256)
         for (int i = 0; i < 4*l; i++) begin
            b = 8'($urandom);
            fr.push_back(b);
            x ^= b;
         end
      fr.push_back(bad ? x ^ 8'h5A : x);
   endtask
   task automatic load_t2();
      fr.delete();
      foreach (t2[i]) fr.push_back(t2[i]);
   endtask
   task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
      int n;
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.rx_data = b;
      bus.rx_valid = 1'b1;
      n = 0;
      while (!bus.rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = n < 50;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask
   task automatic run(input string tag, input bit do_start, input int gapmax, input bit inject);
      logic ed, ee;
      int ew, en;
      bit ok;
      model(ed, ee, ew, en);
      wq.delete();
      dbl = 0;
      if (do_start) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      chk({tag, "_ready"}, 48'(bus.rx_ready), 48'd1);
      for (int i = 0; i < en; i++) begin
         start = inject && i >= 3 && i < en - 1 && $urandom_range(0, 2) == 0;
         send_byte(fr[i], $urandom_range(0, gapmax), ok);
         start = 1'b0;
         if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout byte=%0d actual=no_ready required=ready", tag, i);
            break;
         end
      end
      @(negedge clk);
      chk({tag, "_done"}, 48'(done), 48'(ed));
      chk({tag, "_error"}, 48'(error), 48'(ee));
      chk({tag, "_hold"}, 48'(core_hold), 48'(!ed));
      chk({tag, "_words"}, 48'(words_loaded), 48'(ew));
      chk({tag, "_ready_end"}, 48'(bus.rx_ready), 48'd0);
      chk({tag, "_nwr"}, 48'(wq.size()), 48'(eq.size()));
      for (int i = 0; i < eq.size() && i < wq.size(); i++) chk({tag, "_wr"}, 48'(wq[i]), 48'(eq[i]));
      chk({tag, "_we_single"}, 48'(dbl), 48'd0);
   endtask
   task automatic reset_check(input string tag);
      arst = 1'b1;
      repeat (2) @(negedge clk);
      chk({tag, "_ready"}, 48'(bus.rx_ready), 48'd0);
      chk({tag, "_we"}, 48'(bus.mem_we), 48'd0);
      chk({tag, "_addr"}, 48'(bus.mem_addr), 48'd0);
      chk({tag, "_wdata"}, 48'(bus.mem_wdata), 48'd0);
      chk({tag, "_hold"}, 48'(core_hold), 48'd1);
      chk({tag, "_done"}, 48'(done), 48'd0);
      chk({tag, "_error"}, 48'(error), 48'd0);
      chk({tag, "_words"}, 48'(words_loaded), 48'd0);
      arst = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_ready"}, 48'(bus.rx_ready), 48'd0);
      chk({tag, "_idle_hold"}, 48'(core_hold), 48'd1);
   endtask
   task automatic t2_words(input string tag);
      if (wq.size() == 2) begin
         chk({tag, "_w0"}, 48'(wq[0]), {8'h00, 8'h00, 32'h00000513});
         chk({tag, "_w1"}, 48'(wq[1]), {8'h00, 8'h01, 32'h00100093});
      end
   endtask
   initial begin
      bit ok;
      int l;
      tv[0] = '{0, 1'b0, 1'b0, 1'b1, 0};
      tv[1] = '{257, 1'b0, 1'b0, 1'b1, 0};
      tv[2] = '{65535, 1'b0, 1'b0, 1'b1, 0};
      tv[3] = '{1, 1'b0, 1'b1, 1'b0, 1};
      tv[4] = '{1, 1'b1, 1'b0, 1'b1, 1};
      tv[5] = '{3, 1'b0, 1'b1, 1'b0, 3};
      tv[6] = '{256, 1'b0, 1'b1, 1'b0, 256};
      t2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h95};
      arst = 1'b1; start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
      @(negedge clk);
      reset_check("rst0");
      load_t2();
      run("t2", 1'b1, 0, 1'b0);
      t2_words("t2");
      chk("t2_done_const", 48'(done), 48'd1);
      reset_check("rst1");
      start = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h02;
      @(negedge clk);
      start = 1'b0; bus.rx_valid = 1'b0;
      run("t_sv", 1'b0, 0, 1'b0);
      wq.delete();
      bus.rx_valid = 1'b1; bus.rx_data = 8'hAA;
      repeat (4) @(negedge clk);
      bus.rx_valid = 1'b0;
      chk("ign_done", 48'(done), 48'd1);
      chk("ign_words", 48'(words_loaded), 48'd2);
      chk("ign_nwr", 48'(wq.size()), 48'd0);
      load_t2();
      fr[10] = 8'h00;
      run("t3", 1'b1, 0, 1'b0);
      chk("t3_error_const", 48'(error), 48'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("retry_error", 48'(error), 48'd0);
      chk("retry_hold", 48'(core_hold), 48'd1);
      chk("retry_words", 48'(words_loaded), 48'd0);
      load_t2();
      run("retry", 1'b0, 0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         load_t2();
         run("t5", 1'b1, 3, 1'b1);
         t2_words("t5");
      end
      load_t2();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 7; i++) send_byte(fr[i], 0, ok);
      arst = 1'b1;
      repeat (2) @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
      chk("t6_hold", 48'(core_hold), 48'd1);
      chk("t6_ready", 48'(bus.rx_ready), 48'd0);
      chk("t6_done", 48'(done), 48'd0);
      chk("t6_words", 48'(words_loaded), 48'd0);
      run("t6", 1'b1, 1, 1'b0);
      t2_words("t6");
      for (int k = 0; k < 7; k++) begin
         build(tv[k].len, tv[k].bad);
         run("tv", 1'b1, 0, 1'b0);
         chk("tv_done", 48'(done), 48'(tv[k].e_done));
         chk("tv_error", 48'(error), 48'(tv[k].e_err));
         chk("tv_words", 48'(words_loaded), 48'(tv[k].e_words));
      end
      for (int k = 0; k < 20; k++) begin
         l = $urandom_range(0, 9) == 0 ? 257 + int'($urandom_range(0, 100)) : int'($urandom_range(1, 8));
         build(l, $urandom_range(0, 3) == 0);
         run("rnd", 1'b1, 2, 1'b1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
